// File: rtl/vx_warp_barrier_pkg.sv
// Shared barrier types and sizing for the warp barrier controller.
// Widths follow the per-core warp and barrier counts.
package vx_warp_barrier_pkg;

  localparam int CFG_NUM_WARPS    = 4;
  localparam int CFG_NUM_BARRIERS = 4;

  function automatic int up(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  localparam int NW_BITS = $clog2(CFG_NUM_WARPS);
  localparam int NB_BITS = $clog2(CFG_NUM_BARRIERS);
  localparam int NW_W    = up(NW_BITS);
  localparam int NB_W    = up(NB_BITS);

  typedef struct packed {
    logic            valid;
    logic [NB_W-1:0] id;
    logic [NW_W-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic [NB_W-1:0]          id;
    logic [CFG_NUM_WARPS-1:0] wmask;
  } barrier_release_t;

  localparam int GPU_BARRIER_BITS     = $bits(gpu_barrier_t);
  localparam int GPU_BARRIER_REL_BITS = $bits(barrier_release_t);

endpackage

// File: rtl/vx_barrier_entry.sv
// One barrier id: waiting-warp mask, arrival count and active flag.
// A warp already in the mask is re-set but never counted twice.
module vx_barrier_entry #(
  parameter int NUM_WARPS = 4,
  parameter int CW        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [CW-1:0]        wid,
  input  logic [CW-1:0]        size_m1,
  input  logic                 clear,
  output logic                 is_last,
  output logic [NUM_WARPS-1:0] wmask
);

  logic          active;
  logic [CW-1:0] count;
  logic [CW-1:0] open_size;
  logic [CW:0]   cnt_inc;
  logic          fresh;
  logic          hit;

  always_comb begin
    cnt_inc = {1'b0, count} + {{CW{1'b0}}, 1'b1};
    fresh   = !wmask[wid];
    hit     = active ? (cnt_inc == {1'b0, size_m1})
                     : (size_m1 == '0);
    is_last = fresh && hit;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wmask     <= '0;
      active    <= 1'b0;
      count     <= '0;
      open_size <= '0;
    end else if (arrive) begin
      wmask[wid] <= 1'b1;
      if (fresh && !hit) begin
        if (!active) begin
          active    <= 1'b1;
          count     <= '0;
          open_size <= size_m1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  a_size_match : assert property (
    @(posedge clk) disable iff (reset)
    (arrive && active) |-> (size_m1 == open_size)
  );

endmodule

// File: rtl/vx_warp_barrier.sv
// Per-core warp barrier: stalls arriving warps, releases them together
// once the last participant of a barrier id arrives.
module vx_warp_barrier
  import vx_warp_barrier_pkg::*;
#(
  parameter int NUM_WARPS    = CFG_NUM_WARPS,
  parameter int NUM_BARRIERS = CFG_NUM_BARRIERS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  gpu_barrier_t         req_barrier,
  input  logic [NW_W-1:0]      req_wid,
  output logic                 req_ready,
  output logic                 rel_valid,
  output logic [NB_W-1:0]      rel_id,
  output logic [NUM_WARPS-1:0] rel_wmask,
  input  logic                 rel_ready,
  output logic [NUM_WARPS-1:0] stalled_wmask
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RELEASE = 1'b1;

  logic [0:0]              state;
  logic                    accept;
  logic                    handshake;
  logic [NUM_BARRIERS-1:0] arrive;
  logic [NUM_BARRIERS-1:0] clear;
  logic [NUM_BARRIERS-1:0] is_last;
  logic [NUM_WARPS-1:0]    emask [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    wbit;
  logic [NUM_WARPS-1:0]    stall_n;

  assign req_ready = (state == IDLE);
  assign accept    = req_barrier.valid && req_ready;
  assign handshake = rel_valid && rel_ready;
  assign wbit      = NUM_WARPS'(1) << req_wid;

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_ent
    vx_barrier_entry #(
      .NUM_WARPS (NUM_WARPS),
      .CW        (NW_W)
    ) u_ent (
      .clk     (clk),
      .reset   (reset),
      .arrive  (arrive[b]),
      .wid     (req_wid),
      .size_m1 (req_barrier.size_m1),
      .clear   (clear[b]),
      .is_last (is_last[b]),
      .wmask   (emask[b])
    );
  end

  // Next stalled view mirrors the entries after this edge's arrive/clear.
  always_comb begin
    arrive  = '0;
    clear   = '0;
    stall_n = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      arrive[b] = accept && (req_barrier.id == NB_W'(b));
      clear[b]  = handshake && (rel_id == NB_W'(b));
      if (!clear[b]) stall_n = stall_n | emask[b];
    end
    if (accept) stall_n = stall_n | wbit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rel_valid     <= 1'b0;
      rel_id        <= '0;
      rel_wmask     <= '0;
      stalled_wmask <= '0;
    end else begin
      stalled_wmask <= stall_n;
      unique case (1'b1)
        (state == IDLE): begin
          if (accept && is_last[req_barrier.id]) begin
            state     <= RELEASE;
            rel_valid <= 1'b1;
            rel_id    <= req_barrier.id;
            rel_wmask <= emask[req_barrier.id] | wbit;
          end
        end
        (state == RELEASE): begin
          if (rel_ready) begin
            state     <= IDLE;
            rel_valid <= 1'b0;
            rel_id    <= '0;
            rel_wmask <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_restall : assert property (
    @(posedge clk) disable iff (reset)
    accept |-> !stalled_wmask[req_wid]
  );

endmodule

// File: tb/tb_vx_warp_barrier.sv
// Table-driven bench for vx_warp_barrier with an expected-output queue.
// Each row drives one cycle; its expectation is checked after the edge.
module tb_vx_warp_barrier;
  import vx_warp_barrier_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  gpu_barrier_t req_barrier;
  logic [1:0]   req_wid;
  logic         req_ready;
  logic         rel_valid;
  logic [1:0]   rel_id;
  logic [3:0]   rel_wmask;
  logic         rel_ready;
  logic [3:0]   stalled_wmask;

  always #5 clk = ~clk;

  vx_warp_barrier dut (
    .clk           (clk),
    .reset         (reset),
    .req_barrier   (req_barrier),
    .req_wid       (req_wid),
    .req_ready     (req_ready),
    .rel_valid     (rel_valid),
    .rel_id        (rel_id),
    .rel_wmask     (rel_wmask),
    .rel_ready     (rel_ready),
    .stalled_wmask (stalled_wmask)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] id;
    logic [1:0] sz;
    logic [1:0] w;
    logic       rr;
    logic       e_rdy;
    logic       e_rv;
    logic [1:0] e_rid;
    logic [3:0] e_rm;
    logic [3:0] e_st;
  } vec_t;

  typedef struct {
    int         idx;
    logic       rdy;
    logic       rv;
    logic [1:0] rid;
    logic [3:0] rm;
    logic [3:0] st;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, v, input logic [1:0] id, sz, w,
                     input logic rr, e_rdy, e_rv, input logic [1:0] e_rid,
                     input logic [3:0] e_rm, e_st);
    tbl.push_back('{rst, v, id, sz, w, rr, e_rdy, e_rv, e_rid, e_rm, e_st});
  endtask

  task automatic step(input int idx, input vec_t t);
    exp_t e;
    @(negedge clk);
    reset           = t.rst;
    req_barrier     = '{valid: t.v, id: t.id, size_m1: t.sz};
    req_wid         = t.w;
    rel_ready       = t.rr;
    sb.push_back('{idx, t.e_rdy, t.e_rv, t.e_rid, t.e_rm, t.e_st});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("req_ready", e.idx, 32'(req_ready), 32'(e.rdy));
    check("rel_valid", e.idx, 32'(rel_valid), 32'(e.rv));
    check("rel_id", e.idx, 32'(rel_id), 32'(e.rid));
    check("rel_wmask", e.idx, 32'(rel_wmask), 32'(e.rm));
    check("stalled_wmask", e.idx, 32'(stalled_wmask), 32'(e.st));
  endtask

  initial begin
    reset = 1'b1;
    req_barrier = '0;
    req_wid = '0;
    rel_ready = 1'b0;

    // rst v id sz w rr | rdy rv rid rmask stall
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000);
    // single-warp barrier
    add(0, 1, 1, 0, 2, 0, 0, 1, 1, 4'b0100, 4'b0100);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000);
    // four-warp barrier with a held release
    add(0, 1, 0, 3, 0, 0, 1, 0, 0, 4'b0000, 4'b0001);
    add(0, 1, 0, 3, 1, 0, 1, 0, 0, 4'b0000, 4'b0011);
    add(0, 1, 0, 3, 2, 0, 1, 0, 0, 4'b0000, 4'b0111);
    add(0, 1, 0, 3, 3, 0, 0, 1, 0, 4'b1111, 4'b1111);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 4'b1111);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000);
    // two interleaved barriers; last one back-pressured
    add(0, 1, 2, 1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001);
    add(0, 1, 3, 1, 2, 0, 1, 0, 0, 4'b0000, 4'b0101);
    add(0, 1, 2, 1, 1, 0, 0, 1, 2, 4'b0011, 4'b0111);
    add(0, 1, 3, 1, 3, 0, 0, 1, 2, 4'b0011, 4'b0111);
    add(0, 1, 3, 1, 3, 1, 1, 0, 0, 4'b0000, 4'b0100);
    add(0, 1, 3, 1, 3, 0, 0, 1, 3, 4'b1100, 4'b1100);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000);
    // reset with one barrier partly filled and a release pending
    add(0, 1, 0, 3, 0, 0, 1, 0, 0, 4'b0000, 4'b0001);
    add(0, 1, 0, 3, 1, 0, 1, 0, 0, 4'b0000, 4'b0011);
    add(0, 1, 1, 0, 2, 0, 0, 1, 1, 4'b0100, 4'b0111);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, 2, 0, 3, 0, 0, 1, 2, 4'b1000, 4'b1000);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000);
    // id 0 count must have been wiped: size 3 needs three fresh arrivals
    add(0, 1, 0, 2, 0, 0, 1, 0, 0, 4'b0000, 4'b0001);
    add(0, 1, 0, 2, 1, 0, 1, 0, 0, 4'b0000, 4'b0011);
    add(0, 1, 0, 2, 2, 0, 0, 1, 0, 4'b0111, 4'b0111);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000);

    foreach (tbl[i]) step(i, tbl[i]);

    // rel_ready while idle must be ignored, and an open barrier survives it
    begin
      vec_t h;
      h = '{0, 1, 1, 1, 0, 1, 1, 0, 0, 4'b0000, 4'b0001};
      step(100, h);
      h = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0001};
      step(101, h);
      h = '{0, 1, 1, 1, 3, 0, 0, 1, 1, 4'b1001, 4'b1001};
      step(102, h);
      h = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000};
      step(103, h);
    end

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %0d left want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_warp_barrier.md
# vx_warp_barrier

Per-core warp barrier controller. It consumes `gpu_barrier_t` requests issued by the GPU unit when a warp executes a `bar` instruction and tracks arrivals per barrier id. It stalls arriving warps and, once the last participant arrives, issues a single release mask to the warp scheduler. It sits between the GPU unit's barrier output and the scheduler's warp-stall and warp-resume inputs.

## Interface
- `NUM_WARPS`, default `` `NUM_WARPS `` (4): warps per core.
- `NUM_BARRIERS`, default `` `NUM_BARRIERS `` (4): barrier ids; id width is `` `NB_BITS ``.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_barrier`  in  `` `GPU_BARRIER_BITS ``  `gpu_barrier_t` {valid, id, size_m1}; `valid` is the request strobe.
- `req_wid`  in  `` `UP(`NW_BITS) ``  id of the arriving warp.
- `req_ready`  out  1  request accepted when `req_barrier.valid && req_ready`.
- `rel_valid`  out  1  release pending.
- `rel_id`  out  `` `NB_BITS ``  barrier being released.
- `rel_wmask`  out  `NUM_WARPS`  warps to resume.
- `rel_ready`  in  1  scheduler accepts the release.
- `stalled_wmask`  out  `NUM_WARPS`  OR over all barriers of waiting warps.

## Operation
- Each barrier entry holds `wmask[NUM_WARPS]` and `count`, where `count` is `` `UP(`NW_BITS) `` wide and equals arrivals−1 when the entry is non-empty. A separate `active` bit marks a non-empty entry. All entries are zero at reset.
- States: IDLE, where `rel_valid`=0 and `req_ready`=1, and RELEASE, where `rel_valid`=1 and `req_ready`=0.
- Accepted request to id `b` from warp `w`:
  - Set `wmask[b][w]` in every case.
  - Last arrival: true when `!active[b] ? (size_m1==0) : (count[b]+1 == size_m1)`, compared at full width with no wrap.
    - If true: latch `rel_id=b` and `rel_wmask = wmask[b] | (1<<w)`, then go to RELEASE.
    - Otherwise: if `!active[b]`, set `active` and `count=0`; if active, increment `count`; stay in IDLE.
- RELEASE: the outputs hold stable until `rel_ready`. On the handshake edge, clear `wmask[b]`, `active[b]` and `count[b]`, then return to IDLE.
- `size_m1` is taken from each request. A mismatch against the value that opened the barrier is a software error. The simulation assertion fires; the RTL still uses the latest value.
- A request from a warp whose bit is already set in `stalled_wmask` is illegal and is caught by an assertion. The RTL must not double-count that warp. Its bit is simply re-set.
- `stalled_wmask` is the OR of all `wmask[]` entries, registered. It therefore includes the releasing warp until the release handshake completes.
- Reset mid-operation clears every entry and returns to IDLE. All outputs go to 0 except `req_ready`, which goes to 1.

## Timing
- All outputs are registered, except `req_ready`, which is a direct decode of the state (`!rel_valid`).
- Arrival latency: a request accepted in cycle T shows the warp's bit in `stalled_wmask` in T+1.
- Release latency: when the last arrival is accepted in T, `rel_valid`=1 in T+1 with `rel_id` and `rel_wmask` valid.
- Handshake: when `rel_valid && rel_ready` occurs in cycle R, the released bits are clear in `stalled_wmask` at R+1 and `rel_valid`=0 at R+1. A new request can be accepted at R+1. Back-to-back release every two cycles is the maximum rate.
- Requests presented while in RELEASE are back-pressured. The requester holds `req_barrier` and `req_wid` stable until `req_ready`.
- One request per cycle. `rel_ready` asserted with `rel_valid`=0 is ignored.

## Structure
- Add a `barrier_release_t` {id, wmask} typedef to `VX_gpu_types` next to `gpu_barrier_t`. Add a `` `GPU_BARRIER_REL_BITS `` width macro alongside the existing `$bits` macros.
- One sub-module: `vx_barrier_entry`, instantiated `NUM_BARRIERS` times. It holds wmask, count and active, and exposes `arrive`, `clear`, `is_last` and `wmask`.
- The top level holds the IDLE/RELEASE FSM, the release register and the `stalled_wmask` OR-reduction. Expected size is about 180 RTL lines.

## Test plan
Tests run with `NUM_WARPS`=4 and `NUM_BARRIERS`=4.
- Reset, then idle: `req_ready`=1, `rel_valid`=0, `stalled_wmask`=0000.
- size_m1=0, warp 2, id 1: at T+1, `rel_valid`=1, `rel_id`=1, `rel_wmask`=0100, `stalled_wmask`=0100. With `rel_ready`=1, everything is 0 at the next cycle.
- size_m1=3, id 0, warps 0,1,2 in successive cycles: `stalled_wmask` goes 0001, 0011, 0111, with no release. Warp 3 then gives `rel_wmask`=1111. Hold `rel_ready`=0 for 5 cycles: outputs stay stable and `req_ready`=0. After the handshake, `stalled_wmask`=0000.
- Interleave two barriers, size_m1=1 each: warps 0 and 1 go to id 2, warps 2 and 3 go to id 3. Expect two separate releases, 0011 on id 2 and then 1100 on id 3. Entries are independent and there is no cross-count.
- Back-pressure: a request arriving during RELEASE is held and accepted in the cycle after the handshake, updating `stalled_wmask` at the following cycle.
- Reset asserted while a barrier holds 0011 and another release is pending: the next cycle shows all state cleared, and a fresh size_m1=0 request releases normally.
